alu32_cmd_seq: RTL

Multi-cycle command sequencer that sits directly upstream of the 32-bit ALU and also consumes its outputs.
- Holds an 8x32 register file and accepts register-addressed commands over a valid/ready handshake.
- Drives operands and op code into the ALU, then captures the result and c/n/z/v flags.
- Writes the result back to the destination register and pulses done.

---
 rtl/alu32_cmd_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu32_cmd_seq.sv
// Command sequencer for an external combinational 32-bit ALU: 8x32 register file, IDLE/EXEC/WB FSM.
// Optional macro ALU32_CMP_EN adds cmd_nowb (suppress writeback for compare/test commands).
module alu32_cmd_seq #(
    parameter int NREG    = 8,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_ra,
    input  logic [2:0]  cmd_rb,
    input  logic [2:0]  cmd_rd,
`ifdef ALU32_CMP_EN
    input  logic        cmd_nowb,
`endif
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_c,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    output logic        done,
    output logic [31:0] res_q,
    output logic [3:0]  flags_q,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] opa_q, opb_q;
    logic [2:0]  op_q, rd_q;
    logic        nowb_q;
    logic        accept;
    logic        wb_en;
    logic [31:0] rf [NREG];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured once at accept and drive the ALU until the next accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q <= '0;
            opb_q <= '0;
            op_q  <= '0;
            rd_q  <= '0;
        end else if (accept) begin
            opa_q <= rf[cmd_ra];
            opb_q <= rf[cmd_rb];
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
        end
    end

`ifdef ALU32_CMP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nowb_q <= 1'b0;
        end else if (accept) begin
            nowb_q <= cmd_nowb;
        end
    end
`else
    assign nowb_q = 1'b0;
`endif

    assign alu_a  = opa_q;
    assign alu_b  = opb_q;
    assign alu_op = op_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q   <= '0;
            flags_q <= '0;
        end else if (state_q == EXEC) begin
            res_q   <= alu_result;
            flags_q <= {alu_c, alu_n, alu_z, alu_v};
        end
    end

    assign wb_en = (state_q == WB) && !nowb_q;

    // One register per entry; writeback takes priority over a same-edge direct load.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
        if (ZERO_R0 && gi == 0) begin : g_zero
            assign rf[gi] = '0;
        end else begin : g_reg
            logic [31:0] r_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_q <= '0;
                end else if (wb_en && rd_q == 3'(gi)) begin
                    r_q <= res_q;
                end else if (ld_en && ld_addr == 3'(gi)) begin
                    r_q <= ld_data;
                end
            end
            assign rf[gi] = r_q;
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule
